// File: rtl/chimp_pkg.sv
// Shared types and constants for the chimp-test click judge.
package chimp_pkg;

    localparam int unsigned GRID_DIM         = 8;
    localparam int unsigned COORD_W          = 3;
    localparam int unsigned DEF_MAX_TILES    = 16;
    localparam int unsigned DEF_IDX_W        = 4;
    localparam int unsigned DEF_STRIKE_LIMIT = 3;
    localparam int unsigned STRIKE_W         = 2;

    // Round controller states.
    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ARMED,
        DONE,
        GAMEOVER
    } state_e;

    // Grid position of one tile: column then row.
    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } tile_pos_t;

endpackage

// File: rtl/chimp_tile_match.sv
// Finds the lowest-index live tile sitting on the clicked grid box.
module chimp_tile_match
    import chimp_pkg::*;
#(
    parameter int unsigned MAX_TILES = DEF_MAX_TILES,
    parameter int unsigned IDX_W     = DEF_IDX_W
) (
    input  tile_pos_t            box,
    input  tile_pos_t            tiles [MAX_TILES],
    input  logic [MAX_TILES-1:0] alive,
    output logic                 hit,
    output logic [IDX_W-1:0]     hit_idx
);

    logic [MAX_TILES-1:0] match_c;

    // Per-slot compare; cleared tiles never match.
    always_comb begin
        match_c = '0;
        for (int i = 0; i < int'(MAX_TILES); i++) begin
            match_c[i] = alive[i] && (tiles[i] == box);
        end
    end

    // Priority encode with the lowest index winning.
    always_comb begin
        hit     = |match_c;
        hit_idx = '0;
        for (int i = int'(MAX_TILES) - 1; i >= 0; i--) begin
            if (match_c[i]) begin
                hit_idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/chimp_click_judge.sv
// Chimp-test round controller: loads a tile layout, judges clicks in order,
// and reports tile clears, round pass/fail and strike/game-over status.
module chimp_click_judge
    import chimp_pkg::*;
#(
    parameter int unsigned MAX_TILES    = DEF_MAX_TILES,
    parameter int unsigned IDX_W        = DEF_IDX_W,
    parameter int unsigned STRIKE_LIMIT = DEF_STRIKE_LIMIT
) (
    input  logic                 clk,
    input  logic                 iReset,
    input  logic                 iStart,
    input  logic [IDX_W:0]       iCount,
    input  logic                 iLoadValid,
    input  logic [COORD_W-1:0]   iLoadX,
    input  logic [COORD_W-1:0]   iLoadY,
    output logic                 oLoadReady,
    input  logic                 iClick,
    input  logic [COORD_W-1:0]   iBoxX,
    input  logic [COORD_W-1:0]   iBoxY,
    input  logic                 iInGrid,
    output logic [IDX_W-1:0]     oNextIdx,
    output logic [MAX_TILES-1:0] oAlive,
    output logic                 oHidden,
    output logic                 oPass,
    output logic                 oFail,
    output logic [STRIKE_W-1:0]  oStrikes,
    output logic                 oGameOver
);

    localparam int unsigned CNT_W = IDX_W + 1;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [CNT_W-1:0]      load_idx_q, load_idx_d;
    tile_pos_t             tiles_q [MAX_TILES];
    tile_pos_t             tiles_d [MAX_TILES];
    logic [MAX_TILES-1:0]  alive_q, alive_d;
    logic [IDX_W-1:0]      next_idx_q, next_idx_d;
    logic                  hidden_q, hidden_d;
    logic                  pass_q, pass_d;
    logic                  fail_q, fail_d;
    logic [STRIKE_W-1:0]   strikes_q, strikes_d;
    logic                  game_over_q, game_over_d;
    logic                  load_ready_q, load_ready_d;
    logic                  click_d_q, click_d_d;

    logic                  start_ok_c;
    logic                  open_round_c;
    logic [CNT_W-1:0]      count_clamp_c;
    tile_pos_t             box_c;
    logic                  hit_c;
    logic [IDX_W-1:0]      hit_idx_c;

    // Box indices arrive one cycle after the press, so the pulse is delayed to line up.
    assign click_d_d     = iClick;
    assign start_ok_c    = iStart && (iCount != '0);
    assign count_clamp_c = (iCount > CNT_W'(MAX_TILES)) ? CNT_W'(MAX_TILES) : iCount;
    assign box_c         = tile_pos_t'{x: iBoxX, y: iBoxY};

    chimp_tile_match #(
        .MAX_TILES (MAX_TILES),
        .IDX_W     (IDX_W)
    ) u_match (
        .box     (box_c),
        .tiles   (tiles_q),
        .alive   (alive_q),
        .hit     (hit_c),
        .hit_idx (hit_idx_c)
    );

    // Next-state and output logic for the round controller.
    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        load_idx_d   = load_idx_q;
        tiles_d      = tiles_q;
        alive_d      = alive_q;
        next_idx_d   = next_idx_q;
        hidden_d     = hidden_q;
        pass_d       = 1'b0;
        fail_d       = 1'b0;
        strikes_d    = strikes_q;
        game_over_d  = game_over_q;
        open_round_c = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                open_round_c = start_ok_c;
            end

            LOAD: begin
                if (iLoadValid) begin
                    tiles_d[load_idx_q[IDX_W-1:0]] = tile_pos_t'{x: iLoadX, y: iLoadY};
                    alive_d[load_idx_q[IDX_W-1:0]] = 1'b1;
                    load_idx_d                     = load_idx_q + CNT_W'(1);
                    if (load_idx_d == count_q) begin
                        state_d = ARMED;
                    end
                end
            end

            ARMED: begin
                // A restart overrides any click judged in the same cycle.
                if (start_ok_c) begin
                    open_round_c = 1'b1;
                end else if (click_d_q && iInGrid && hit_c) begin
                    if (hit_idx_c == next_idx_q) begin
                        alive_d[hit_idx_c] = 1'b0;
                        next_idx_d         = next_idx_q + IDX_W'(1);
                        hidden_d           = 1'b1;
                        if ((CNT_W'(next_idx_q) + CNT_W'(1)) == count_q) begin
                            pass_d  = 1'b1;
                            state_d = DONE;
                        end
                    end else begin
                        fail_d  = 1'b1;
                        alive_d = '0;
                        if (strikes_q != '1) begin
                            strikes_d = strikes_q + STRIKE_W'(1);
                        end
                        if (strikes_d == STRIKE_W'(STRIKE_LIMIT)) begin
                            game_over_d = 1'b1;
                            state_d     = GAMEOVER;
                        end else begin
                            state_d = DONE;
                        end
                    end
                end
            end

            GAMEOVER: begin
                if (start_ok_c) begin
                    strikes_d    = '0;
                    game_over_d  = 1'b0;
                    open_round_c = 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Common round opening: fresh board, layout load begins.
        if (open_round_c) begin
            count_d    = count_clamp_c;
            load_idx_d = '0;
            alive_d    = '0;
            next_idx_d = '0;
            hidden_d   = 1'b0;
            state_d    = LOAD;
        end

        load_ready_d = (state_d == LOAD);
    end

    // Control and status registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!iReset) begin
            state_q      <= IDLE;
            count_q      <= '0;
            load_idx_q   <= '0;
            alive_q      <= '0;
            next_idx_q   <= '0;
            hidden_q     <= 1'b0;
            pass_q       <= 1'b0;
            fail_q       <= 1'b0;
            strikes_q    <= '0;
            game_over_q  <= 1'b0;
            load_ready_q <= 1'b0;
            click_d_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            load_idx_q   <= load_idx_d;
            alive_q      <= alive_d;
            next_idx_q   <= next_idx_d;
            hidden_q     <= hidden_d;
            pass_q       <= pass_d;
            fail_q       <= fail_d;
            strikes_q    <= strikes_d;
            game_over_q  <= game_over_d;
            load_ready_q <= load_ready_d;
            click_d_q    <= click_d_d;
        end
    end

    // Tile layout storage; contents are only meaningful where alive is set.
    always_ff @(posedge clk) begin
        tiles_q <= tiles_d;
    end

    assign oLoadReady = load_ready_q;
    assign oNextIdx   = next_idx_q;
    assign oAlive     = alive_q;
    assign oHidden    = hidden_q;
    assign oPass      = pass_q;
    assign oFail      = fail_q;
    assign oStrikes   = strikes_q;
    assign oGameOver  = game_over_q;

endmodule

// File: tb/tb_chimp_click_judge.sv
// Bench for chimp_click_judge: directed vector table, corner sequences,
// then randomized traffic against a behavioural round model.
module tb_chimp_click_judge;

    logic        clk;
    logic        iReset;
    logic        iStart;
    logic [4:0]  iCount;
    logic        iLoadValid;
    logic [2:0]  iLoadX, iLoadY;
    logic        oLoadReady;
    logic        iClick;
    logic [2:0]  iBoxX, iBoxY;
    logic        iInGrid;
    logic [3:0]  oNextIdx;
    logic [15:0] oAlive;
    logic        oHidden, oPass, oFail;
    logic [1:0]  oStrikes;
    logic        oGameOver;

    int tests  = 0;
    int failed = 0;

    chimp_click_judge dut (
        .clk        (clk),
        .iReset     (iReset),
        .iStart     (iStart),
        .iCount     (iCount),
        .iLoadValid (iLoadValid),
        .iLoadX     (iLoadX),
        .iLoadY     (iLoadY),
        .oLoadReady (oLoadReady),
        .iClick     (iClick),
        .iBoxX      (iBoxX),
        .iBoxY      (iBoxY),
        .iInGrid    (iInGrid),
        .oNextIdx   (oNextIdx),
        .oAlive     (oAlive),
        .oHidden    (oHidden),
        .oPass      (oPass),
        .oFail      (oFail),
        .oStrikes   (oStrikes),
        .oGameOver  (oGameOver)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural reference model ----------------
    localparam int M_IDLE = 0, M_LOAD = 1, M_ARMED = 2, M_DONE = 3, M_GO = 4;
    int        m_mode = M_IDLE;
    bit        m_click_d = 0;
    int        m_px [16];
    int        m_py [16];
    bit [15:0] m_alive = 0;
    int        m_next = 0, m_count = 0, m_loaded = 0, m_strikes = 0;
    bit        m_hid = 0, m_pass = 0, m_fail = 0, m_go = 0;

    task automatic model_begin(input int n);
        m_count  = (n > 16) ? 16 : n;
        m_loaded = 0;
        m_alive  = 0;
        m_next   = 0;
        m_hid    = 0;
        m_mode   = M_LOAD;
    endtask

    always @(posedge clk) begin : model_p
        bit judge;
        bit start_ok;
        int cand;
        judge     = m_click_d;
        m_click_d = iClick;
        m_pass    = 0;
        m_fail    = 0;
        start_ok  = iStart && (iCount != 0);
        if (!iReset) begin
            m_mode = M_IDLE; m_click_d = 0; m_alive = 0; m_next = 0; m_hid = 0;
            m_strikes = 0; m_go = 0; m_loaded = 0; m_count = 0;
        end else begin
            case (m_mode)
                M_IDLE, M_DONE: if (start_ok) model_begin(int'(iCount));
                M_LOAD: begin
                    if (iLoadValid) begin
                        m_px[m_loaded]    = int'(iLoadX);
                        m_py[m_loaded]    = int'(iLoadY);
                        m_alive[m_loaded] = 1'b1;
                        m_loaded++;
                        if (m_loaded == m_count) m_mode = M_ARMED;
                    end
                end
                M_ARMED: begin
                    if (start_ok) begin
                        model_begin(int'(iCount));
                    end else if (judge && iInGrid) begin
                        cand = -1;
                        for (int i = 0; i < m_count; i++)
                            if (cand < 0 && m_alive[i] && m_px[i] == int'(iBoxX) && m_py[i] == int'(iBoxY))
                                cand = i;
                        if (cand >= 0 && cand == m_next) begin
                            m_alive[cand] = 1'b0;
                            m_next++;
                            m_hid = 1;
                            if (m_next == m_count) begin m_pass = 1; m_mode = M_DONE; end
                        end else if (cand >= 0) begin
                            m_fail  = 1;
                            m_alive = 0;
                            if (m_strikes < 3) m_strikes++;
                            if (m_strikes == 3) begin m_go = 1; m_mode = M_GO; end
                            else m_mode = M_DONE;
                        end
                    end
                end
                M_GO: begin
                    if (start_ok) begin
                        m_strikes = 0;
                        m_go      = 0;
                        model_begin(int'(iCount));
                    end
                end
                default: m_mode = M_IDLE;
            endcase
        end
    end

    // ---------------- helpers ----------------
    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_in();
        iStart = 0; iCount = 0; iLoadValid = 0; iLoadX = 0; iLoadY = 0;
        iClick = 0; iBoxX = 0; iBoxY = 0; iInGrid = 0;
    endtask

    task automatic chk(input string nm, input logic [15:0] ea, input logic [3:0] en,
                       input logic eh, input logic ep, input logic ef, input logic er,
                       input logic [1:0] es, input logic eg);
        tests++;
        if ({oAlive, oNextIdx, oHidden, oPass, oFail, oLoadReady, oStrikes, oGameOver} !==
            {ea, en, eh, ep, ef, er, es, eg}) begin
            failed++;
            $display("FAIL %s @%0t: got alive=%h nxt=%0d hid=%b pass=%b fail=%b rdy=%b strk=%0d go=%b; want alive=%h nxt=%0d hid=%b pass=%b fail=%b rdy=%b strk=%0d go=%b",
                     nm, $time, oAlive, oNextIdx, oHidden, oPass, oFail, oLoadReady, oStrikes, oGameOver,
                     ea, en, eh, ep, ef, er, es, eg);
        end
    endtask

    task automatic do_start(input int n);
        idle_in(); iStart = 1; iCount = 5'(n); cyc();
    endtask

    task automatic do_load(input int x, input int y);
        idle_in(); iLoadValid = 1; iLoadX = 3'(x); iLoadY = 3'(y); cyc();
    endtask

    // Press pulse, then box indices one cycle later (optionally with a restart).
    task automatic do_click(input int x, input int y, input bit ing, input bit st);
        idle_in(); iClick = 1; cyc();
        idle_in(); iBoxX = 3'(x); iBoxY = 3'(y); iInGrid = ing;
        if (st) begin iStart = 1; iCount = 5'd3; end
        cyc();
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        rst_n, st;  logic [4:0] cnt;
        logic        lv;  logic [2:0] lx, ly;
        logic        ck;  logic [2:0] bx, by; logic ing;
        logic [15:0] alive; logic [3:0] nxt; logic hid, pas, fal, rdy; logic [1:0] strk; logic go;
    } vec_t;
    vec_t vecs[$];

    function automatic vec_t v(input logic r, input logic s, input int c, input logic lv,
                               input int lx, input int ly, input logic ck, input int bx,
                               input int by, input logic ing, input logic [15:0] a,
                               input int n, input logic h, input logic p, input logic f,
                               input logic rd, input int sk, input logic g);
        vec_t t;
        t.rst_n = r; t.st = s; t.cnt = 5'(c); t.lv = lv; t.lx = 3'(lx); t.ly = 3'(ly);
        t.ck = ck; t.bx = 3'(bx); t.by = 3'(by); t.ing = ing;
        t.alive = a; t.nxt = 4'(n); t.hid = h; t.pas = p; t.fal = f; t.rdy = rd;
        t.strk = 2'(sk); t.go = g;
        return t;
    endfunction

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        idle_in();
        iReset = 0;

        //               rst st cnt lv lx ly ck bx by ing | alive  n h p f r s g
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(v(1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 16'h0, 0, 0, 0, 0, 1, 0, 0));
        vecs.push_back(v(1, 0, 0, 1, 1, 2, 0, 0, 0, 0, 16'h1, 0, 0, 0, 0, 1, 0, 0));
        vecs.push_back(v(1, 0, 0, 1, 4, 0, 0, 0, 0, 0, 16'h3, 0, 0, 0, 0, 1, 0, 0));
        vecs.push_back(v(1, 0, 0, 1, 7, 7, 0, 0, 0, 0, 16'h7, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(v(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 16'h7, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(v(1, 0, 0, 0, 0, 0, 0, 1, 2, 1, 16'h6, 1, 1, 0, 0, 0, 0, 0));
        vecs.push_back(v(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 16'h6, 1, 1, 0, 0, 0, 0, 0));
        vecs.push_back(v(1, 0, 0, 0, 0, 0, 0, 4, 0, 1, 16'h4, 2, 1, 0, 0, 0, 0, 0));
        vecs.push_back(v(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 16'h4, 2, 1, 0, 0, 0, 0, 0));
        vecs.push_back(v(1, 0, 0, 0, 0, 0, 0, 7, 7, 1, 16'h0, 3, 1, 1, 0, 0, 0, 0));
        vecs.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0, 3, 1, 0, 0, 0, 0, 0));
        vecs.push_back(v(1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 16'h0, 0, 0, 0, 0, 1, 0, 0));
        vecs.push_back(v(1, 0, 0, 1, 1, 2, 0, 0, 0, 0, 16'h1, 0, 0, 0, 0, 1, 0, 0));
        vecs.push_back(v(1, 0, 0, 1, 4, 0, 0, 0, 0, 0, 16'h3, 0, 0, 0, 0, 1, 0, 0));
        vecs.push_back(v(1, 0, 0, 1, 7, 7, 0, 0, 0, 0, 16'h7, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(v(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 16'h7, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(v(1, 0, 0, 0, 0, 0, 0, 3, 3, 1, 16'h7, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(v(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 16'h7, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(v(1, 0, 0, 0, 0, 0, 0, 1, 2, 0, 16'h7, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(v(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 16'h7, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(v(1, 0, 0, 0, 0, 0, 0, 1, 2, 1, 16'h6, 1, 1, 0, 0, 0, 0, 0));
        vecs.push_back(v(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 16'h6, 1, 1, 0, 0, 0, 0, 0));
        vecs.push_back(v(1, 0, 0, 0, 0, 0, 0, 1, 2, 1, 16'h6, 1, 1, 0, 0, 0, 0, 0));
        vecs.push_back(v(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 16'h6, 1, 1, 0, 0, 0, 0, 0));
        vecs.push_back(v(1, 0, 0, 0, 0, 0, 0, 7, 7, 1, 16'h0, 1, 1, 0, 1, 0, 1, 0));
        vecs.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0, 1, 1, 0, 0, 0, 1, 0));
        vecs.push_back(v(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 16'h0, 1, 1, 0, 0, 0, 1, 0));
        vecs.push_back(v(1, 0, 0, 0, 0, 0, 0, 7, 7, 1, 16'h0, 1, 1, 0, 0, 0, 1, 0));
        vecs.push_back(v(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0, 1, 1, 0, 0, 0, 1, 0));

        foreach (vecs[k]) begin
            iReset = vecs[k].rst_n; iStart = vecs[k].st; iCount = vecs[k].cnt;
            iLoadValid = vecs[k].lv; iLoadX = vecs[k].lx; iLoadY = vecs[k].ly;
            iClick = vecs[k].ck; iBoxX = vecs[k].bx; iBoxY = vecs[k].by; iInGrid = vecs[k].ing;
            cyc();
            chk($sformatf("vec%0d", k), vecs[k].alive, vecs[k].nxt, vecs[k].hid, vecs[k].pas,
                vecs[k].fal, vecs[k].rdy, vecs[k].strk, vecs[k].go);
        end
        iReset = 1;

        // Two more failed rounds (wrong tile first) reach the strike limit.
        for (int k = 2; k <= 3; k++) begin
            do_start(3);
            chk("fail_round_start", 16'h0, 0, 0, 0, 0, 1, 2'(k - 1), 0);
            do_load(1, 2); do_load(4, 0); do_load(7, 7);
            chk("fail_round_loaded", 16'h7, 0, 0, 0, 0, 0, 2'(k - 1), 0);
            do_click(4, 0, 1, 0);
            chk("wrong_tile_first", 16'h0, 0, 0, 0, 1, 0, 2'(k), (k == 3));
        end
        do_click(1, 2, 1, 0);
        chk("click_in_gameover", 16'h0, 0, 0, 0, 0, 0, 3, 1);
        do_start(3);
        chk("gameover_restart", 16'h0, 0, 0, 0, 0, 1, 0, 0);

        // Start during LOAD is ignored: round still ends after 3 entries.
        idle_in(); iStart = 1; iCount = 5'd5; iLoadValid = 1; iLoadX = 3'd1; iLoadY = 3'd2; cyc();
        chk("start_in_load", 16'h1, 0, 0, 0, 0, 1, 0, 0);
        do_load(4, 0); do_load(7, 7);
        chk("load_count_kept", 16'h7, 0, 0, 0, 0, 0, 0, 0);

        // Abort from ARMED with an oversize count that clamps to 16 tiles.
        do_start(20);
        chk("abort_clamp_start", 16'h0, 0, 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 16; i++) begin
            do_load(i % 8, i / 8);
            if (i == 14) chk("clamp_15th", 16'h7fff, 0, 0, 0, 0, 1, 0, 0);
        end
        chk("clamp_16th", 16'hffff, 0, 0, 0, 0, 0, 0, 0);

        // Restart coincident with a wrong judged click: restart wins, no strike.
        do_click(1, 0, 1, 1);
        chk("start_beats_click", 16'h0, 0, 0, 0, 0, 1, 0, 0);
        do_load(1, 2); do_load(4, 0); do_load(7, 7);
        chk("reload_after_restart", 16'h7, 0, 0, 0, 0, 0, 0, 0);

        // Back-to-back clicks each judged against the updated state.
        idle_in(); iClick = 1; cyc();
        chk("b2b_press", 16'h7, 0, 0, 0, 0, 0, 0, 0);
        idle_in(); iClick = 1; iBoxX = 3'd1; iBoxY = 3'd2; iInGrid = 1; cyc();
        chk("b2b_first", 16'h6, 1, 1, 0, 0, 0, 0, 0);
        idle_in(); iBoxX = 3'd4; iBoxY = 3'd0; iInGrid = 1; cyc();
        chk("b2b_second", 16'h4, 2, 1, 0, 0, 0, 0, 0);
        do_click(7, 7, 1, 0);
        chk("b2b_pass", 16'h0, 3, 1, 1, 0, 0, 0, 0);

        // Reset in the middle of LOAD clears everything.
        do_start(3);
        do_load(1, 2);
        chk("pre_reset_load", 16'h1, 0, 0, 0, 0, 1, 0, 0);
        idle_in(); iClick = 1; iReset = 0; cyc();
        chk("reset_mid_load", 16'h0, 0, 0, 0, 0, 0, 0, 0);
        idle_in(); iReset = 1; iBoxX = 3'd1; iBoxY = 3'd2; iInGrid = 1; cyc();
        chk("after_reset", 16'h0, 0, 0, 0, 0, 0, 0, 0);

        // Randomized traffic against the model.
        idle_in(); iReset = 0; cyc();
        chk("rand_reset", m_alive, 4'(m_next), m_hid, m_pass, m_fail, (m_mode == M_LOAD), 2'(m_strikes), m_go);
        for (int c = 0; c < 3000; c++) begin
            idle_in();
            iReset = ($urandom_range(0, 299) != 0);
            iClick = ($urandom_range(0, 2) == 0);
            iBoxX  = 3'($urandom_range(0, 7));
            iBoxY  = 3'($urandom_range(0, 3));
            iInGrid = ($urandom_range(0, 7) != 0);
            case (m_mode)
                M_LOAD: begin
                    if ($urandom_range(0, 3) != 0) begin
                        iLoadValid = 1;
                        iLoadX = 3'($urandom_range(0, 7));
                        iLoadY = 3'($urandom_range(0, 3));
                    end
                    if ($urandom_range(0, 19) == 0) begin iStart = 1; iCount = 5'($urandom); end
                end
                M_ARMED: begin
                    iClick = ($urandom_range(0, 1) == 0);
                    if (m_click_d) begin
                        int r;
                        int t;
                        r = int'($urandom_range(0, 9));
                        if (r < 6) t = m_next % 16;
                        else       t = int'($urandom_range(0, 15)) % m_count;
                        if (r < 8) begin iBoxX = 3'(m_px[t]); iBoxY = 3'(m_py[t]); end
                    end
                    if ($urandom_range(0, 39) == 0) begin iStart = 1; iCount = 5'($urandom_range(0, 20)); end
                end
                default: begin
                    if ($urandom_range(0, 3) == 0) begin iStart = 1; iCount = 5'($urandom_range(0, 20)); end
                end
            endcase
            cyc();
            chk("rand", m_alive, 4'(m_next), m_hid, m_pass, m_fail, (m_mode == M_LOAD), 2'(m_strikes), m_go);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/chimp_click_judge.md
# chimp_click_judge

Chimp-test round controller sitting directly downstream of `chimpMouseClick`. It stores the grid layout of the numbered tiles for the current round and consumes registered box coordinates plus the mouse left-click pulse. It judges each click against the expected next tile and emits per-tile clear, round pass/fail and strike/game-over status to the renderer and score logic.

## Interface
- `MAX_TILES`, 16: tile slots per round.
- `IDX_W`, 4: clog2(`MAX_TILES`).
- `STRIKE_LIMIT`, 3: failed rounds allowed before game over.

- `clk`  in  1  single system clock.
- `iReset`  in  1  synchronous, active-low reset.
- `iStart`  in  1  pulse; begins a round by opening the layout load.
- `iCount`  in  IDX_W+1  tiles in the round; sampled with `iStart`.
- `iLoadValid`  in  1  layout entry valid; entries arrive in tile order 0..count-1.
- `iLoadX`, `iLoadY`  in  3 each  grid column/row of the current entry.
- `oLoadReady`  out  1  high only in LOAD.
- `iClick`  in  1  one-cycle left-press pulse, coincident with the mouse coordinates presented to `chimpMouseClick`.
- `iBoxX`, `iBoxY`  in  3 each  registered box indices from `chimpMouseClick`.
- `iInGrid`  in  1  box valid flag; same latency as `iBoxX`/`iBoxY`.
- `oNextIdx`  out  IDX_W  index of the next tile to click.
- `oAlive`  out  MAX_TILES  bit i set means tile i is still displayed.
- `oHidden`  out  1  numbers masked; set after the first correct click of a round.
- `oPass`, `oFail`  out  1 each  one-cycle round-result pulses.
- `oStrikes`  out  2  failed rounds so far.
- `oGameOver`  out  1  level; strike limit reached.

## Operation
- Reset, with `iReset`=0 sampled at an edge: state IDLE. All outputs 0. Tile RAM contents are don't-care.
- States and transitions:
  - IDLE, ARMED, or DONE: `iStart` with `iCount`=0 is ignored. Otherwise `iCount` is clamped to `MAX_TILES`. Then: `oAlive` cleared, `oNextIdx`=0, `oHidden`=0, go to LOAD.
  - LOAD: each `iLoadValid`&`oLoadReady` cycle writes {X,Y} to slot `load_idx` and sets `oAlive[load_idx]`. After the count-th write, go to ARMED.
  - ARMED: judges clicks (below).
  - DONE: entered after a pass or after a non-final fail.
  - GAMEOVER: entered when `oStrikes` reaches `STRIKE_LIMIT`. `iStart` here clears `oStrikes` and `oGameOver`, then enters LOAD.
- `iStart` in ARMED aborts the round with no strike and restarts LOAD. `iStart` in LOAD is ignored.
- Click alignment: `iClick` is delayed one cycle internally (`click_d`). `iBoxX`/`iBoxY`/`iInGrid` are sampled in the `click_d` cycle.
- Judgement in ARMED on `click_d`&`iInGrid`. Candidates are tiles with `oAlive` set whose stored position equals the clicked box; the lowest-index candidate is taken.
  - No candidate: ignored. This covers empty squares, squares of already-cleared tiles, and `iInGrid`=0.
  - Candidate index == `oNextIdx`: clear its alive bit, `oNextIdx`+1, set `oHidden`. If it was the last tile: pulse `oPass`, go to DONE.
  - Candidate index != `oNextIdx`: pulse `oFail`, `oStrikes`+1, clear all of `oAlive`. Go to GAMEOVER with `oGameOver`=1 if the new count equals `STRIKE_LIMIT`, else DONE.
- Clicks in IDLE, LOAD, DONE and GAMEOVER are ignored.
- `oStrikes` saturates; it never wraps.

## Timing
- Click to result: `iClick` at cycle t, judged at t+1; `oAlive`/`oNextIdx`/`oPass`/`oFail`/`oStrikes` update at the t+2 edge.
- A second `iClick` at t+1 is judged at t+2 against the already-updated state. Back-to-back clicks are fully supported.
- Load throughput is one entry per cycle. `oLoadReady` drops the cycle after the final write.
- Reset mid-round discards everything, including any in-flight `click_d`.
- `iStart` coincident with `click_d` in ARMED: `iStart` wins and the click is dropped.

## Structure
- Package `chimp_pkg`: `GRID_DIM`=8, `COORD_W`=3, state enum {IDLE, LOAD, ARMED, DONE, GAMEOVER}, default `MAX_TILES`.
- Sub-module `chimp_tile_match`: combinational compare of the clicked box against all slots gated by `oAlive`. Outputs `hit` and `hit_idx`, using a priority encoder with the lowest index winning.
- Tile storage is a register array of `MAX_TILES` × 6 bits, with no RAM inference required.

## Test plan
- Reset, then drive `iStart` with `iCount`=3 and load (1,2),(4,0),(7,7) -> `oAlive`=0x0007, `oLoadReady` low after the 3rd write, state ARMED.
- Click boxes (1,2),(4,0),(7,7) in order -> `oNextIdx` 1,2 then `oPass` pulse. `oHidden`=1 after the first click. `oAlive`=0 at the end.
- With the same layout, click (4,0) first -> `oFail` pulse, `oStrikes`=1, `oAlive`=0, state DONE.
- Click empty (3,3), cleared (1,2) after it is cleared, and `iInGrid`=0 -> no change to any output.
- Three consecutive failed rounds -> `oStrikes`=3, `oGameOver`=1. The next `iStart` clears both and enters LOAD.
- Assert reset mid-LOAD, and separately `iStart` on the same cycle as a judged click -> all outputs 0, and restart wins with no strike counted, respectively.
